// File: rtl/peak_window_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// peak_window_if: AD sample request/return and result valid/ready bus. Rev 1.0
// ----------------------------------------------------------------------------
interface peak_window_if #(
    parameter int unsigned DATA_W = 9
);
    logic              sample_stb;
    logic [DATA_W-1:0] ad_data;
    logic              ad_valid;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_max;
    logic [DATA_W-1:0] res_min;
    logic [DATA_W-1:0] res_pp;
    logic [31:0]       res_cnt;
    logic              res_empty;

    modport master (
        output sample_stb,
        input  ad_data,
        input  ad_valid,
        output res_valid,
        input  res_ready,
        output res_max,
        output res_min,
        output res_pp,
        output res_cnt,
        output res_empty
    );

    modport slave (
        input  sample_stb,
        output ad_data,
        output ad_valid,
        input  res_valid,
        output res_ready,
        input  res_max,
        input  res_min,
        input  res_pp,
        input  res_cnt,
        input  res_empty
    );
endinterface
`default_nettype wire

// File: rtl/peak_window_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// peak_window_ctrl: periodic sample strobe, fixed windows, max/min/pp result. Rev 1.0
// ----------------------------------------------------------------------------
module peak_window_ctrl #(
    parameter logic [31:0] WIN_LEN    = 32'h005F_A000,
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned DATA_W     = 9
) (
    input  wire logic     clock,
    input  wire logic     rst_n,
    input  wire logic     start_i,
    input  wire logic     stop_i,
    output logic          busy_o,
    output logic          overrun_o,
    peak_window_if.master bus
);

    localparam int unsigned       DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [31:0]       WIN_LAST = WIN_LEN - 32'd1;
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CLOSE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       win_cnt_q, win_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_max_q, res_max_d;
    logic [DATA_W-1:0] res_min_q, res_min_d;
    logic [DATA_W-1:0] res_pp_q, res_pp_d;
    logic [31:0]       res_cnt_q, res_cnt_d;
    logic              res_empty_q, res_empty_d;
    logic              overrun_q, overrun_d;

    logic              handshake;
    logic [DIV_W-1:0]  div_next;
    logic [31:0]       cnt_inc;
    logic [DATA_W:0]   max_diff;
    logic [DATA_W:0]   min_diff;
    logic [DATA_W-1:0] max_upd;
    logic [DATA_W-1:0] min_upd;

    // Unsigned compare one bit wider: the top bit is the borrow, set when ad_data < tracker.
    assign max_diff = {1'b0, bus.ad_data} - {1'b0, max_q};
    assign min_diff = {1'b0, bus.ad_data} - {1'b0, min_q};
    assign max_upd  = max_diff[DATA_W] ? max_q : bus.ad_data;
    assign min_upd  = min_diff[DATA_W] ? bus.ad_data : min_q;

    assign handshake = res_valid_q && bus.res_ready;
    assign div_next  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        div_cnt_d   = div_cnt_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        min_d       = min_q;
        res_max_d   = res_max_q;
        res_min_d   = res_min_q;
        res_pp_d    = res_pp_q;
        res_cnt_d   = res_cnt_q;
        res_empty_d = res_empty_q;
        overrun_d   = overrun_q;
        res_valid_d = handshake ? 1'b0 : res_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    win_cnt_d = '0;
                    div_cnt_d = '0;
                    cnt_d     = '0;
                    max_d     = '0;
                    min_d     = ALL_ONES;
                    overrun_d = 1'b0;
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    state_d   = S_IDLE;
                    win_cnt_d = '0;
                    div_cnt_d = '0;
                    cnt_d     = '0;
                    max_d     = '0;
                    min_d     = ALL_ONES;
                end else begin
                    win_cnt_d = win_cnt_q + 32'd1;
                    div_cnt_d = div_next;
                    if (bus.ad_valid) begin
                        max_d = max_upd;
                        min_d = min_upd;
                        cnt_d = cnt_inc;
                    end
                    if (win_cnt_q == WIN_LAST) begin
                        state_d = S_CLOSE;
                    end
                end
            end
            S_CLOSE: begin
                if (stop_i) begin
                    state_d   = S_IDLE;
                    win_cnt_d = '0;
                    div_cnt_d = '0;
                    cnt_d     = '0;
                    max_d     = '0;
                    min_d     = ALL_ONES;
                end else begin
                    state_d     = S_RUN;
                    win_cnt_d   = '0;
                    div_cnt_d   = div_next;
                    res_cnt_d   = cnt_q;
                    res_empty_d = (cnt_q == 32'd0);
                    res_max_d   = (cnt_q == 32'd0) ? '0 : max_q;
                    res_min_d   = (cnt_q == 32'd0) ? '0 : min_q;
                    res_pp_d    = (cnt_q == 32'd0) ? '0 : (max_q - min_q);
                    // A fresh result always wins over a same-cycle consume.
                    res_valid_d = 1'b1;
                    if (res_valid_q && !bus.res_ready) begin
                        overrun_d = 1'b1;
                    end
                    // A sample arriving in CLOSE opens the next window.
                    max_d = bus.ad_valid ? bus.ad_data : '0;
                    min_d = bus.ad_valid ? bus.ad_data : ALL_ONES;
                    cnt_d = bus.ad_valid ? 32'd1 : 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        stb_d  = (state_d != S_IDLE) && (div_cnt_d == '0);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            win_cnt_q   <= '0;
            div_cnt_q   <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
            min_q       <= ALL_ONES;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_max_q   <= '0;
            res_min_q   <= '0;
            res_pp_q    <= '0;
            res_cnt_q   <= '0;
            res_empty_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            div_cnt_q   <= div_cnt_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            stb_q       <= stb_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_max_q   <= res_max_d;
            res_min_q   <= res_min_d;
            res_pp_q    <= res_pp_d;
            res_cnt_q   <= res_cnt_d;
            res_empty_q <= res_empty_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.sample_stb = stb_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_max    = res_max_q;
    assign bus.res_min    = res_min_q;
    assign bus.res_pp     = res_pp_q;
    assign bus.res_cnt    = res_cnt_q;
    assign bus.res_empty  = res_empty_q;
    assign busy_o         = busy_q;
    assign overrun_o      = overrun_q;

endmodule
`default_nettype wire
